// File: rtl/mem_request_arbiter.sv
// Single-port RAM arbiter shared by instruction fetch and data load/store.
// Each instruction runs IFETCH, an optional DACCESS, then a one-cycle COMMIT.
module mem_request_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic [ADDR_W-1:0]   imemaddr,
    input  logic [ADDR_W-1:0]   dmmaddr,
    input  logic [DATA_W-1:0]   dmmstore,
    input  logic                dmm_read,
    input  logic                dmm_write,
    input  logic [1:0]          dmm_size,
    input  logic                dmm_unsigned,
    input  logic                busy_o,
    input  logic [DATA_W-1:0]   ramload,
    output logic                Ren,
    output logic                Wen,
    output logic [ADDR_W-1:0]   ramaddr,
    output logic [DATA_W-1:0]   ramstore,
    output logic [DATA_W/8-1:0] ram_be,
    output logic [DATA_W-1:0]   imemload,
    output logic [DATA_W-1:0]   dmmload,
    output logic                i_wait,
    output logic                d_wait,
    output logic                misalign_err,
    output logic                timeout_err
);

    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(BE_W - 1));

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_IFETCH  = 2'd1,
        S_DACCESS = 2'd2,
        S_COMMIT  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [DATA_W-1:0]   r_imemload;
    logic [DATA_W-1:0]   r_dmmload;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_timeout_err;
    logic [DATA_W-1:0]   w_imem_nxt;
    logic [DATA_W-1:0]   w_dmm_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_to_nxt;
    logic [OFF_W-1:0]    w_off;
    logic [DATA_W-1:0]   w_shifted;
    logic                w_misalign;
    logic                w_dreq;
    logic                w_timeout_hit;

    function automatic logic [BE_W-1:0] lane_mask(input logic [1:0] size);
        logic [BE_W-1:0] m;
        case (size)
            2'd0:    m = BE_W'(1);
            2'd1:    m = BE_W'(3);
            2'd2:    m = BE_W'(15);
            default: m = '1;
        endcase
        return m;
    endfunction

    function automatic logic [DATA_W-1:0] replicate(input logic [DATA_W-1:0] d, input logic [1:0] size);
        logic [DATA_W-1:0] r;
        case (size)
            2'd0:    r = {BE_W{d[7:0]}};
            2'd1:    r = {(BE_W / 2){d[15:0]}};
            2'd2:    r = {(BE_W / 4){d[31:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] d, input logic [1:0] size,
                                                      input logic uns);
        logic [DATA_W-1:0] mask;
        logic              sign;
        case (size)
            2'd0:    begin mask = DATA_W'(8'hFF);        sign = d[7];        end
            2'd1:    begin mask = DATA_W'(16'hFFFF);     sign = d[15];       end
            2'd2:    begin mask = DATA_W'(32'hFFFF_FFFF); sign = d[31];       end
            default: begin mask = '1;                    sign = d[DATA_W-1]; end
        endcase
        if (sign && !uns) begin
            return d | ~mask;
        end else begin
            return d & mask;
        end
    endfunction

    assign w_off         = dmmaddr[OFF_W-1:0];
    assign w_shifted     = ramload >> {w_off, 3'b000};
    assign w_dreq        = dmm_read | dmm_write;
    assign w_timeout_hit = busy_o && (TIMEOUT_CYC > 0) && (r_cnt == CNT_LAST);

    assign imemload    = r_imemload;
    assign dmmload     = r_dmmload;
    assign timeout_err = r_timeout_err;

    // Alignment check: offset must be a multiple of the access size; dword needs a 64-bit bus
    always_comb begin
        case (dmm_size)
            2'd0:    w_misalign = 1'b0;
            2'd1:    w_misalign = w_off[0];
            2'd2:    w_misalign = |w_off[1:0];
            default: w_misalign = (DATA_W == 32) ? 1'b1 : (|w_off);
        endcase
    end

    // Next-state, RAM request outputs and register next values
    always_comb begin
        w_next       = r_state;
        Ren          = 1'b0;
        Wen          = 1'b0;
        ramaddr      = '0;
        ramstore     = '0;
        ram_be       = '0;
        i_wait       = 1'b1;
        d_wait       = 1'b1;
        misalign_err = 1'b0;
        w_imem_nxt   = r_imemload;
        w_dmm_nxt    = r_dmmload;
        w_cnt_nxt    = r_cnt;
        w_to_nxt     = r_timeout_err;
        case (r_state)
            S_IDLE: begin
                w_next    = S_IFETCH;
                w_cnt_nxt = '0;
            end
            S_IFETCH: begin
                Ren     = 1'b1;
                ramaddr = imemaddr & ALIGN_MASK;
                ram_be  = '1;
                d_wait  = 1'b0;
                // The core presents the decode of the fetched word on dmm_read/dmm_write
                if (!busy_o) begin
                    w_imem_nxt = ramload;
                    w_cnt_nxt  = '0;
                    w_next     = w_dreq ? S_DACCESS : S_COMMIT;
                end else if (w_timeout_hit) begin
                    w_to_nxt = 1'b1;
                    w_next   = S_COMMIT;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DACCESS: begin
                i_wait  = 1'b0;
                ramaddr = dmmaddr & ALIGN_MASK;
                if (!w_dreq) begin
                    w_next = S_COMMIT;
                end else if (w_misalign) begin
                    misalign_err = 1'b1;
                    w_dmm_nxt    = '0;
                    w_next       = S_COMMIT;
                end else begin
                    if (dmm_write) begin
                        Wen      = 1'b1;
                        ram_be   = lane_mask(dmm_size) << w_off;
                        ramstore = replicate(dmmstore, dmm_size);
                    end else begin
                        Ren    = 1'b1;
                        ram_be = '1;
                    end
                    if (!busy_o) begin
                        w_next = S_COMMIT;
                        if (!dmm_write) begin
                            w_dmm_nxt = extend_load(w_shifted, dmm_size, dmm_unsigned);
                        end else begin
                            w_dmm_nxt = r_dmmload;
                        end
                    end else if (w_timeout_hit) begin
                        w_to_nxt = 1'b1;
                        w_next   = S_COMMIT;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            S_COMMIT: begin
                i_wait    = 1'b0;
                d_wait    = 1'b0;
                w_cnt_nxt = '0;
                w_next    = S_IFETCH;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State and result registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state       <= S_IDLE;
            r_imemload    <= '0;
            r_dmmload     <= '0;
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_imemload    <= w_imem_nxt;
            r_dmmload     <= w_dmm_nxt;
            r_cnt         <= w_cnt_nxt;
            r_timeout_err <= w_to_nxt;
        end
    end

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed bench for mem_request_arbiter (32-bit data, 4-cycle busy timeout).
module tb_mem_request_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          nRST;
    logic [AW-1:0] imemaddr, dmmaddr, ramaddr;
    logic [DW-1:0] dmmstore, ramload, ramstore, imemload, dmmload;
    logic          dmm_read, dmm_write, dmm_unsigned, busy_o;
    logic [1:0]    dmm_size;
    logic          Ren, Wen, i_wait, d_wait, misalign_err, timeout_err;
    logic [3:0]    ram_be;

    mem_request_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(4)) dut (
        .CLK(CLK), .nRST(nRST), .imemaddr(imemaddr), .dmmaddr(dmmaddr), .dmmstore(dmmstore),
        .dmm_read(dmm_read), .dmm_write(dmm_write), .dmm_size(dmm_size), .dmm_unsigned(dmm_unsigned),
        .busy_o(busy_o), .ramload(ramload), .Ren(Ren), .Wen(Wen), .ramaddr(ramaddr),
        .ramstore(ramstore), .ram_be(ram_be), .imemload(imemload), .dmmload(dmmload),
        .i_wait(i_wait), .d_wait(d_wait), .misalign_err(misalign_err), .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end of the sequence");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] q_exp[$];
    string       q_tag[$];
    int          n_pass   = 0;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        exp_to   = 1'b0;

    // status word: {Ren, Wen, i_wait, d_wait, misalign_err, timeout_err}
    function automatic logic [31:0] stat();
        return {26'd0, Ren, Wen, i_wait, d_wait, misalign_err, timeout_err};
    endfunction

    function automatic logic [31:0] st(input logic [5:0] x);
        return {26'd0, x[5:1], exp_to};
    endfunction

    task automatic push(input string tag, input logic [31:0] v);
        q_tag.push_back(tag);
        q_exp.push_back(v);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_checks++;
        if (q_exp.size() == 0) begin
            n_fail++;
            $error("FAIL sb_underflow: got %h required <none>", obs);
        end else begin
            t = q_tag.pop_front();
            e = q_exp.pop_front();
            assert (obs === e) n_pass++;
            else begin
                n_fail++;
                $error("FAIL %s: got %h required %h", t, obs, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Complete a zero-wait fetch; entered and left #1 after a rising edge
    task automatic fetch(input logic [31:0] addr, input logic [31:0] instr, input logic rd, input logic wr);
        imemaddr = addr; ramload = instr; busy_o = 1'b0; dmm_read = rd; dmm_write = wr;
        #1;
        push("fetch_stat", st(6'b101000));
        push("fetch_addr", addr & 32'hFFFF_FFFC);
        pop_chk(stat());
        pop_chk(ramaddr);
        tick();
    endtask

    task automatic load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                        input logic [31:0] word, input logic [31:0] exp_val, input int nbusy);
        dmmaddr = addr; dmm_size = size; dmm_unsigned = uns;
        fetch(32'h0000_1000, 32'h0000_0003, 1'b1, 1'b0);
        ramload = word; busy_o = (nbusy > 0);
        #1;
        push("ld_stat", st(6'b100100));
        push("ld_addr", addr & 32'hFFFF_FFFC);
        push("ld_be", 32'h0000_000F);
        pop_chk(stat());
        pop_chk(ramaddr);
        pop_chk({28'd0, ram_be});
        for (int i = 0; i < nbusy; i++) begin
            tick();
            push("ld_hold", st(6'b100100));
            pop_chk(stat());
            if (i == nbusy - 1) busy_o = 1'b0;
        end
        tick();
        push("ld_commit", st(6'b000000));
        push("ld_data", exp_val);
        pop_chk(stat());
        pop_chk(dmmload);
        tick();
    endtask

    task automatic store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data,
                         input logic [3:0] exp_be, input logic [31:0] exp_store);
        dmmaddr = addr; dmm_size = size; dmmstore = data; dmm_unsigned = 1'b0;
        fetch(32'h0000_1004, 32'h0000_0023, 1'b0, 1'b1);
        busy_o = 1'b0;
        #1;
        push("st_stat", st(6'b010100));
        push("st_addr", addr & 32'hFFFF_FFFC);
        push("st_be", {28'd0, exp_be});
        push("st_data", exp_store);
        pop_chk(stat());
        pop_chk(ramaddr);
        pop_chk({28'd0, ram_be});
        pop_chk(ramstore);
        tick();
        push("st_commit", st(6'b000000));
        pop_chk(stat());
        tick();
    endtask

    task automatic misal(input logic [31:0] addr, input logic [1:0] size, input logic rd, input logic wr);
        dmmaddr = addr; dmm_size = size; dmm_unsigned = 1'b0;
        fetch(32'h0000_1008, 32'h0000_0003, rd, wr);
        #1;
        push("mis_stat", st(6'b000110));
        pop_chk(stat());
        tick();
        push("mis_commit", st(6'b000000));
        push("mis_data", 32'h0);
        pop_chk(stat());
        pop_chk(dmmload);
        tick();
    endtask

    initial begin
        nRST = 1'b0; imemaddr = '0; dmmaddr = '0; dmmstore = '0; dmm_read = 1'b0; dmm_write = 1'b0;
        dmm_size = 2'd0; dmm_unsigned = 1'b0; busy_o = 1'b1; ramload = '0;
        repeat (3) tick();
        push("rst_stat", st(6'b001100));
        push("rst_imem", 32'h0);
        push("rst_dmm", 32'h0);
        push("rst_addr", 32'h0);
        push("rst_be", 32'h0);
        pop_chk(stat());
        pop_chk(imemload);
        pop_chk(dmmload);
        pop_chk(ramaddr);
        pop_chk({28'd0, ram_be});

        // Fetch with one busy cycle, no data phase
        imemaddr = 32'hABCD_ABCD; ramload = 32'h1234_1234; busy_o = 1'b1;
        nRST = 1'b1;
        #1;
        push("idle_stat", st(6'b001100));
        pop_chk(stat());
        tick();
        push("t1_stat", st(6'b101000));
        push("t1_addr", 32'hABCD_ABCC);
        pop_chk(stat());
        pop_chk(ramaddr);
        busy_o = 1'b0;
        tick();
        push("t1_commit", st(6'b000000));
        push("t1_imem", 32'h1234_1234);
        pop_chk(stat());
        pop_chk(imemload);
        tick();

        // Loads: byte sign/zero extend, half with busy, word with 3 busy cycles
        load(32'h5678_5679, 2'd0, 1'b0, 32'h4321_4321, 32'h0000_0043, 0);
        load(32'h5678_5679, 2'd0, 1'b0, 32'h4321_8021, 32'hFFFF_FF80, 0);
        load(32'h5678_5679, 2'd0, 1'b1, 32'h4321_8021, 32'h0000_0080, 0);
        load(32'h5678_567A, 2'd1, 1'b0, 32'h8001_1234, 32'hFFFF_8001, 1);

        // Stores: word, byte lane 1, half upper lanes
        store(32'hABCD_ABCC, 2'd2, 32'h3333_3333, 4'hF, 32'h3333_3333);
        store(32'hABCD_ABCD, 2'd0, 32'h0000_00A5, 4'h2, 32'hA5A5_A5A5);
        store(32'hABCD_ABCE, 2'd1, 32'h0000_BEEF, 4'hC, 32'hBEEF_BEEF);

        // Misalignment clears a non-zero dmmload
        misal(32'h3434_3433, 2'd1, 1'b1, 1'b0);
        misal(32'hABCD_0002, 2'd2, 1'b0, 1'b1);
        load(32'h1000_0010, 2'd2, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D, 3);
        misal(32'h0000_0040, 2'd3, 1'b1, 1'b0);

        // Busy stuck high in IFETCH: abort on the 4th busy cycle
        imemaddr = 32'h0000_2000; ramload = 32'hDEAD_BEEF; busy_o = 1'b1;
        dmm_read = 1'b0; dmm_write = 1'b0;
        #1;
        push("to_first", st(6'b101000));
        pop_chk(stat());
        for (int i = 0; i < 3; i++) begin
            tick();
            push("to_hold", st(6'b101000));
            pop_chk(stat());
        end
        tick();
        exp_to = 1'b1;
        push("to_commit", st(6'b000000));
        push("to_imem", 32'h0000_0003);
        pop_chk(stat());
        pop_chk(imemload);
        busy_o = 1'b0;
        tick();
        push("to_sticky", st(6'b101000));
        pop_chk(stat());

        // Reset in the middle of a busy store
        dmmaddr = 32'h0000_0100; dmm_size = 2'd2; dmmstore = 32'h5555_AAAA;
        fetch(32'h0000_2004, 32'h0000_0023, 1'b0, 1'b1);
        busy_o = 1'b1;
        #1;
        push("r6_store", st(6'b010100));
        pop_chk(stat());
        #1;
        nRST = 1'b0;
        #1;
        exp_to = 1'b0;
        push("r6_stat", st(6'b001100));
        push("r6_addr", 32'h0);
        push("r6_be", 32'h0);
        push("r6_data", 32'h0);
        push("r6_imem", 32'h0);
        push("r6_dmm", 32'h0);
        pop_chk(stat());
        pop_chk(ramaddr);
        pop_chk({28'd0, ram_be});
        pop_chk(ramstore);
        pop_chk(imemload);
        pop_chk(dmmload);
        tick();
        nRST = 1'b1;
        #1;
        push("r6_idle", st(6'b001100));
        pop_chk(stat());
        tick();
        push("r6_ifetch", st(6'b101000));
        pop_chk(stat());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
